// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants and the FP32-to-INT32 converter state encoding
package fpu_pkg;
  localparam int FP32_BIAS = 127;
  localparam logic [31:0] INT32_SAT = 32'h8000_0000;
  typedef enum logic [2:0] {
    ST_GET,
    ST_UNPACK,
    ST_SPECIAL,
    ST_CONVERT,
    ST_PACK,
    ST_PUT
  } f2i_state_t;
endpackage

// File: rtl/fp32_to_int32.sv
// fp32_to_int32: iterative FP32 to signed INT32 conversion, round toward zero, saturating
module fp32_to_int32
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_z,
  input  logic        in_z_stb,
  output logic        in_z_ack,
  output logic [31:0] out_i,
  output logic        out_i_stb,
  input  logic        out_i_ack
);
  f2i_state_t         state, state_n;
  logic [31:0]        z, z_n;
  logic               sign, sign_n;
  logic signed [9:0]  exp, exp_n;
  logic [23:0]        man, man_n;
  logic [31:0]        work, work_n;
  logic               in_z_ack_n, out_i_stb_n;
  logic [31:0]        out_i_n;
  // next-state and datapath updates; the shifter moves one bit per cycle until exp reaches 31
  always_comb begin
    state_n     = state;
    z_n         = z;
    sign_n      = sign;
    exp_n       = exp;
    man_n       = man;
    work_n      = work;
    in_z_ack_n  = in_z_ack;
    out_i_n     = out_i;
    out_i_stb_n = out_i_stb;
    case (state)
      ST_GET: begin
        in_z_ack_n = 1'b1;
        if (in_z_ack && in_z_stb) begin
          z_n        = in_z;
          in_z_ack_n = 1'b0;
          state_n    = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_n  = z[31];
        exp_n   = $signed({2'b00, z[30:23]} - 10'(FP32_BIAS));
        man_n   = {1'b1, z[22:0]};
        state_n = ST_SPECIAL;
      end
      ST_SPECIAL: begin
        if (&z[30:23] || exp >= 10'sd31) begin
          out_i_n     = INT32_SAT;
          out_i_stb_n = 1'b1;
          state_n     = ST_PUT;
        end else if (exp < 10'sd0) begin
          out_i_n     = '0;
          out_i_stb_n = 1'b1;
          state_n     = ST_PUT;
        end else begin
          work_n  = {man, 8'h00};
          state_n = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (exp < 10'sd31) begin
          work_n = work >> 1;
          exp_n  = exp + 10'sd1;
        end else begin
          state_n = ST_PACK;
        end
      end
      ST_PACK: begin
        out_i_n     = sign ? ~work + 32'd1 : work;
        out_i_stb_n = 1'b1;
        state_n     = ST_PUT;
      end
      ST_PUT: begin
        if (out_i_stb && out_i_ack) begin
          out_i_stb_n = 1'b0;
          state_n     = ST_GET;
        end
      end
      default: state_n = ST_GET;
    endcase
  end
  // state and datapath registers; reset discards any in-flight conversion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_GET;
      z         <= '0;
      sign      <= 1'b0;
      exp       <= '0;
      man       <= '0;
      work      <= '0;
      in_z_ack  <= 1'b0;
      out_i     <= '0;
      out_i_stb <= 1'b0;
    end else begin
      state     <= state_n;
      z         <= z_n;
      sign      <= sign_n;
      exp       <= exp_n;
      man       <= man_n;
      work      <= work_n;
      in_z_ack  <= in_z_ack_n;
      out_i     <= out_i_n;
      out_i_stb <= out_i_stb_n;
    end
  end
endmodule

// File: tb/tb_fp32_to_int32.sv
// tb_fp32_to_int32: directed vectors with hand-computed results and latencies
module tb_fp32_to_int32;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_z = '0;
  logic        in_z_stb = 1'b0;
  logic        in_z_ack;
  logic [31:0] out_i;
  logic        out_i_stb;
  logic        out_i_ack = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  fp32_to_int32 dut (
    .clk(clk),
    .rst(rst),
    .in_z(in_z),
    .in_z_stb(in_z_stb),
    .in_z_ack(in_z_ack),
    .out_i(out_i),
    .out_i_stb(out_i_stb),
    .out_i_ack(out_i_ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic send(input logic [31:0] zv, output int c0);
    int k = 0;
    @(negedge clk);
    while (!in_z_ack && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ack_ready", 32'(in_z_ack), 32'd1);
    in_z = zv;
    in_z_stb = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    in_z_stb = 1'b0;
  endtask
  task automatic await_out(input int c0, output int lat);
    int k = 0;
    @(negedge clk);
    while (!out_i_stb && k < 80) begin
      @(negedge clk);
      k++;
    end
    lat = cyc - c0;
  endtask
  task automatic convert(input string tag, input logic [31:0] zv, input logic [31:0] want, input int want_lat);
    int c0, lat;
    send(zv, c0);
    await_out(c0, lat);
    chk({tag, "_val"}, out_i, want);
    chk({tag, "_lat"}, 32'(lat), 32'(want_lat));
    out_i_ack = 1'b1;
    @(posedge clk);
    #1;
    out_i_ack = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c0, lat;
    logic seen;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(in_z_ack), 32'd0);
    chk("rst_stb", 32'(out_i_stb), 32'd0);
    chk("rst_out", out_i, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_after_rst", 32'(in_z_ack), 32'd1);
    convert("one", 32'h3F80_0000, 32'h0000_0001, 35);
    convert("half", 32'h3F00_0000, 32'h0000_0000, 2);
    convert("m2p5", 32'hC020_0000, 32'hFFFF_FFFE, 34);
    convert("maxin", 32'h4EFF_FFFF, 32'h7FFF_FF80, 5);
    convert("p2e31", 32'h4F00_0000, 32'h8000_0000, 2);
    convert("m2e31", 32'hCF00_0000, 32'h8000_0000, 2);
    convert("nan", 32'h7FC0_0000, 32'h8000_0000, 2);
    convert("minf", 32'hFF80_0000, 32'h8000_0000, 2);
    convert("mzero", 32'h8000_0000, 32'h0000_0000, 2);
    convert("denorm", 32'h0000_0001, 32'h0000_0000, 2);
    send(32'h4120_0000, c0);
    await_out(c0, lat);
    chk("bp_lat", 32'(lat), 32'd32);
    repeat (10) begin
      @(negedge clk);
      chk("bp_stb", 32'(out_i_stb), 32'd1);
      chk("bp_out", out_i, 32'h0000_000A);
    end
    out_i_ack = 1'b1;
    @(posedge clk);
    #1;
    out_i_ack = 1'b0;
    chk("bp_stb_fall", 32'(out_i_stb), 32'd0);
    chk("bp_ack_low", 32'(in_z_ack), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_ack_rise", 32'(in_z_ack), 32'd1);
    send(32'h3F80_0000, c0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_stb", 32'(out_i_stb), 32'd0);
    chk("mid_rst_ack", 32'(in_z_ack), 32'd0);
    chk("mid_rst_out", out_i, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_ack_rise", 32'(in_z_ack), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_i_stb) seen = 1'b1;
    end
    chk("mid_no_stb", 32'(seen), 32'd0);
    convert("ten", 32'h4120_0000, 32'h0000_000A, 32);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
